// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S frame geometry constants and divider helper
package i2s_pkg;

   localparam int SLOT_BITS   = 32;
   localparam int SAMPLE_BITS = 16;
   localparam int FRAME_SLOTS = 64;

   localparam int SLOT_W  = $clog2(SLOT_BITS);
   localparam int FRAME_W = $clog2(FRAME_SLOTS);
   localparam int IDX_W   = $clog2(SAMPLE_BITS);

   // System clocks per BCLK period for a 64-slot frame
   function automatic int bclk_div(input int clock_rate, input int sample_rate);
      return clock_rate / (sample_rate * FRAME_SLOTS);
   endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// rtl/i2s_clock_gen.sv - free-running BCLK/LRCK generator with frame and bit strobes
module i2s_clock_gen
   import i2s_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic              clk,
   input  logic              I_RSTn,
   output logic [SLOT_W-1:0] slot,
   output logic              frame_start,
   output logic              bclk_fall,
   output logic              bclk,
   output logic              lrck
);

   localparam int               DIV_W    = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);

   logic [DIV_W-1:0]   div_cnt;
   logic [DIV_W-1:0]   div_nxt;
   logic [FRAME_W-1:0] bit_cnt;
   logic [FRAME_W-1:0] bit_nxt;

   // Next divider/slot position; slot counter wraps naturally at 64
   always_comb begin
      div_nxt = div_cnt + 1'b1;
      bit_nxt = bit_cnt;
      if (div_cnt == DIV_LAST) begin
         div_nxt = '0;
         bit_nxt = bit_cnt + 1'b1;
      end
   end

   // Counters and clocks registered together so BCLK/LRCK track the counters exactly
   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         bclk    <= 1'b0;
         lrck    <= 1'b0;
      end else begin
         div_cnt <= div_nxt;
         bit_cnt <= bit_nxt;
         bclk    <= (div_nxt >= DIV_HALF);
         lrck    <= bit_nxt[FRAME_W-1];
      end
   end

   assign slot        = bit_cnt[SLOT_W-1:0];
   assign bclk_fall   = (div_cnt == '0);
   assign frame_start = (div_cnt == '0) && (bit_cnt == '0);

endmodule

// File: rtl/i2s_sample_transmitter.sv
// rtl/i2s_sample_transmitter.sv - mono sample to stereo I2S serializer with under/overrun flags
module i2s_sample_transmitter
   import i2s_pkg::*;
#(
   parameter int CLOCK_RATE  = 12288000,
   parameter int SAMPLE_RATE = 48000
) (
   input  logic                          clk,
   input  logic                          I_RSTn,
   input  logic                          audio_clk_en,
   input  logic signed [SAMPLE_BITS-1:0] sample_in,
   output logic                          i2s_bclk,
   output logic                          i2s_lrck,
   output logic                          i2s_sdata,
   output logic                          underrun,
   output logic                          overrun
);

   localparam int DIV = bclk_div(CLOCK_RATE, SAMPLE_RATE);
   localparam logic [SLOT_W-1:0] DATA_SLOTS = SLOT_W'(SAMPLE_BITS);

   generate
      if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
         $error("i2s_sample_transmitter: CLOCK_RATE/(SAMPLE_RATE*64) must be even and >= 2");
      end
   endgenerate

   logic [SLOT_W-1:0]      slot;
   logic                   frame_start;
   logic                   bclk_fall;
   logic [SAMPLE_BITS-1:0] pending;
   logic                   pending_valid;
   logic [SAMPLE_BITS-1:0] shift_reg;
   logic                   tx_bit;

   i2s_clock_gen #(
      .DIV (DIV)
   ) u_clock_gen (
      .clk         (clk),
      .I_RSTn      (I_RSTn),
      .slot        (slot),
      .frame_start (frame_start),
      .bclk_fall   (bclk_fall),
      .bclk        (i2s_bclk),
      .lrck        (i2s_lrck)
   );

   // Slot 0 is the one-BCLK I2S delay; slots 1..16 carry the sample MSB first, the rest pad with 0
   always_comb begin
      tx_bit = 1'b0;
      if (slot != '0 && slot <= DATA_SLOTS)
         tx_bit = shift_reg[IDX_W'(DATA_SLOTS - slot)];
   end

   // Sample handoff: pending buffer feeds the frame register at each frame start
   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         pending       <= '0;
         pending_valid <= 1'b0;
         shift_reg     <= '0;
         i2s_sdata     <= 1'b0;
         underrun      <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         underrun <= 1'b0;
         overrun  <= 1'b0;
         if (frame_start) begin
            if (pending_valid) begin
               shift_reg     <= pending;
               pending_valid <= 1'b0;
            end else begin
               underrun <= 1'b1;
            end
         end
         // A strobe on a frame start refills pending after the old value moved out above
         if (audio_clk_en) begin
            pending       <= sample_in;
            pending_valid <= 1'b1;
            if (pending_valid && !frame_start)
               overrun <= 1'b1;
         end
         if (bclk_fall)
            i2s_sdata <= tx_bit;
      end
   end

endmodule

// File: tb/tb_i2s_sample_transmitter.sv
// tb/tb_i2s_sample_transmitter.sv - directed-vector bench for i2s_sample_transmitter
module tb_i2s_sample_transmitter;

   logic               clk = 1'b0;
   logic               I_RSTn;
   logic               audio_clk_en;
   logic signed [15:0] sample_in;
   logic               i2s_bclk;
   logic               i2s_lrck;
   logic               i2s_sdata;
   logic               underrun;
   logic               overrun;

   always #5 clk = ~clk;

   i2s_sample_transmitter #(
      .CLOCK_RATE  (12288000),
      .SAMPLE_RATE (48000)
   ) dut (
      .clk          (clk),
      .I_RSTn       (I_RSTn),
      .audio_clk_en (audio_clk_en),
      .sample_in    (sample_in),
      .i2s_bclk     (i2s_bclk),
      .i2s_lrck     (i2s_lrck),
      .i2s_sdata    (i2s_sdata),
      .underrun     (underrun),
      .overrun      (overrun)
   );

   typedef struct packed {
      logic [15:0] left;
      logic [15:0] right;
      logic        pad_ok;
   } frame_t;

   localparam logic [63:0] DATA_MASK = 64'h0001_FFFE_0001_FFFE;

   frame_t fq[$];
   int vec_cnt = 0;
   int err_cnt = 0;
   int ncyc    = 0;

   int          cyc = 0;
   logic        prev_bclk, prev_lrck, last_lrck;
   int          slot;
   logic [63:0] fbits;
   int          last_rise, bclk_per, last_fall, lrck_per, last_und, und_per;
   int          und_cnt, ovr_cnt;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Protocol-level receiver: decodes frames from BCLK rising edges and LRCK
   always @(negedge clk) begin
      logic [63:0] nb;
      int          s;
      frame_t      f;
      cyc <= cyc + 1;
      if (!I_RSTn) begin
         prev_bclk <= 1'b0;
         prev_lrck <= 1'b0;
         last_lrck <= 1'b1;
         slot      <= 63;
         fbits     <= '0;
         last_rise <= -1;
         last_fall <= -1;
         last_und  <= -1;
         bclk_per  <= 0;
         lrck_per  <= 0;
         und_per   <= 0;
         und_cnt   <= 0;
         ovr_cnt   <= 0;
         fq.delete();
      end else begin
         if (underrun) begin
            und_cnt <= und_cnt + 1;
            if (last_und >= 0) und_per <= cyc - last_und;
            last_und <= cyc;
         end
         if (overrun) ovr_cnt <= ovr_cnt + 1;
         if (prev_lrck && !i2s_lrck) begin
            if (last_fall >= 0) lrck_per <= cyc - last_fall;
            last_fall <= cyc;
         end
         prev_lrck <= i2s_lrck;
         prev_bclk <= i2s_bclk;
         if (i2s_bclk && !prev_bclk) begin
            if (last_rise >= 0) bclk_per <= cyc - last_rise;
            last_rise <= cyc;
            s = (!i2s_lrck && last_lrck) ? 0 : slot + 1;
            last_lrck <= i2s_lrck;
            slot <= s;
            nb = fbits;
            nb[s[5:0]] = i2s_sdata;
            fbits <= nb;
            if (s == 63) begin
               for (int i = 0; i < 16; i++) begin
                  f.left[15-i]  = nb[1+i];
                  f.right[15-i] = nb[33+i];
               end
               f.pad_ok = ((nb & ~DATA_MASK) == 64'd0);
               fq.push_back(f);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         ncyc++;
      end
   endtask

   task automatic strobe_at(input int target, input logic [15:0] val);
      tick(target - ncyc);
      audio_clk_en = 1'b1;
      sample_in    = val;
      tick(1);
      audio_clk_en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      I_RSTn       = 1'b0;
      audio_clk_en = 1'b0;
      repeat (3) @(negedge clk);
      I_RSTn = 1'b1;
      ncyc   = 0;
   endtask

   task automatic check_frame(input string tag, input logic [15:0] exp);
      frame_t f;
      int     budget;
      budget = 600;
      while (fq.size() == 0 && budget > 0) begin
         @(negedge clk);
         ncyc++;
         budget--;
      end
      if (fq.size() == 0) begin
         check_vec({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         f = fq.pop_front();
         check_vec(tag, {f.left, f.right}, {exp, exp});
         check_vec({tag, "_pad"}, 32'(f.pad_ok), 32'd1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] v;
      logic [15:0] prev_v;
      I_RSTn       = 1'b0;
      audio_clk_en = 1'b0;
      sample_in    = '0;
      repeat (3) @(negedge clk);
      check_vec("rst_bclk", 32'(i2s_bclk), 32'd0);
      check_vec("rst_lrck", 32'(i2s_lrck), 32'd0);
      check_vec("rst_sdata", 32'(i2s_sdata), 32'd0);
      check_vec("rst_underrun", 32'(underrun), 32'd0);
      check_vec("rst_overrun", 32'(overrun), 32'd0);

      // Idle after release: free-running clocks, silence, underrun every frame
      I_RSTn = 1'b1;
      ncyc   = 0;
      tick(1);
      check_vec("idle_first_underrun", 32'(underrun), 32'd1);
      check_vec("idle_bclk_c1", 32'(i2s_bclk), 32'd0);
      tick(1);
      check_vec("idle_bclk_c2", 32'(i2s_bclk), 32'd1);
      check_vec("idle_underrun_c2", 32'(underrun), 32'd0);
      check_frame("idle_f0", 16'h0000);
      check_frame("idle_f1", 16'h0000);
      check_frame("idle_f2", 16'h0000);
      check_vec("idle_bclk_period", 32'(bclk_per), 32'd4);
      check_vec("idle_lrck_period", 32'(lrck_per), 32'd256);
      check_vec("idle_und_period", 32'(und_per), 32'd256);
      check_vec("idle_und_count", 32'(und_cnt), 32'd3);
      check_vec("idle_ovr_count", 32'(ovr_cnt), 32'd0);

      // Single sample, then repeat with underrun
      do_reset();
      strobe_at(20, 16'hA5C3);
      check_frame("single_f0", 16'h0000);
      check_frame("single_f1", 16'hA5C3);
      check_frame("single_f2_repeat", 16'hA5C3);
      check_vec("single_und_count", 32'(und_cnt), 32'd2);

      // Two strobes in one frame: newest wins, one overrun
      do_reset();
      strobe_at(20, 16'h0001);
      strobe_at(60, 16'h8000);
      check_frame("ovr_f0", 16'h0000);
      check_frame("ovr_f1", 16'h8000);
      check_vec("ovr_count", 32'(ovr_cnt), 32'd1);

      // Strobe coincident with frame start while a sample is pending
      do_reset();
      strobe_at(20, 16'h1234);
      strobe_at(256, 16'h7FFF);
      check_frame("coin_f0", 16'h0000);
      check_frame("coin_f1", 16'h1234);
      check_frame("coin_f2", 16'h7FFF);
      check_vec("coin_ovr_count", 32'(ovr_cnt), 32'd0);
      check_vec("coin_und_count", 32'(und_cnt), 32'd1);

      // Asynchronous reset in the right channel at slot 40
      do_reset();
      strobe_at(20, 16'h1111);
      check_frame("mid_f0", 16'h0000);
      tick(417 - ncyc);
      check_vec("mid_lrck_before", 32'(i2s_lrck), 32'd1);
      #2;
      I_RSTn = 1'b0;
      #1;
      check_vec("mid_rst_bclk", 32'(i2s_bclk), 32'd0);
      check_vec("mid_rst_lrck", 32'(i2s_lrck), 32'd0);
      check_vec("mid_rst_sdata", 32'(i2s_sdata), 32'd0);
      check_vec("mid_rst_underrun", 32'(underrun), 32'd0);
      check_vec("mid_rst_overrun", 32'(overrun), 32'd0);
      repeat (3) @(negedge clk);
      I_RSTn = 1'b1;
      ncyc   = 0;
      check_vec("mid_rel_lrck", 32'(i2s_lrck), 32'd0);
      tick(1);
      check_vec("mid_rel_underrun", 32'(underrun), 32'd1);
      strobe_at(20, 16'h2222);
      check_frame("mid_rel_f0", 16'h0000);
      check_frame("mid_rel_f1", 16'h2222);

      // One strobe per frame for 100 frames: one-frame latency, no flags after the first frame
      do_reset();
      prev_v = 16'h0000;
      for (int k = 0; k <= 100; k++) begin
         v = 16'(k * 1021 + 16'h0F0F);
         strobe_at(20 + 256 * k, v);
         check_frame($sformatf("steady_f%0d", k), prev_v);
         prev_v = v;
      end
      check_vec("steady_und_count", 32'(und_cnt), 32'd1);
      check_vec("steady_ovr_count", 32'(ovr_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
